// File: rtl/cond_flag_unit.sv
// Purpose : holds NZCV flags, evaluates the condition field and gates PCSrc/RegWrite/MemWrite.
// Latency : CondEx combinational; flags and SkipCount update at the edge; enables +1 cycle if REG_OUT.
// Backpres: Stall freezes flags, SkipCount and registered enables; Flush squashes without counting.
//
// Ports
//   CLK, RESET            rising-edge clock, asynchronous active-high reset
//   Cond                  condition field of the current instruction
//   ALUFlags              {N,Z,C,V} produced by the ALU for the current instruction
//   FlagW                 [1] writes N,Z  [0] writes C,V
//   PCS/RegW/MemW         ungated write intents from decode
//   NoWrite               compare-class op, never writes the register file
//   Stall, Flush          pipeline hold / squash
//   PCSrc/RegWrite/MemWrite gated write-enables
//   CondEx                condition passed and not flushed
//   Flags, Carry          architectural flag register and its C bit
//   SkipCount             saturating count of condition-failed instructions
module cond_flag_unit #(
    parameter int CNT_W   = 16,
    parameter bit REG_OUT = 1'b0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    input  logic             Stall,
    input  logic             Flush,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             CondEx,
    output logic [3:0]       Flags,
    output logic             Carry,
    output logic [CNT_W-1:0] SkipCount
);

    // ------------------------------------------------------------------
    // Architectural flag register, layout {N,Z,C,V}
    // ------------------------------------------------------------------
    logic [3:0] flags_q;
    logic       flag_n;
    logic       flag_z;
    logic       flag_c;
    logic       flag_v;

    assign flag_n = flags_q[3];
    assign flag_z = flags_q[2];
    assign flag_c = flags_q[1];
    assign flag_v = flags_q[0];

    // ------------------------------------------------------------------
    // Condition evaluation. Only the registered flags are used: an
    // instruction never sees the flags produced by itself, which matches
    // the architectural ordering of a single-issue pipeline.
    // ------------------------------------------------------------------
    logic cond_pass;

    always_comb begin
        cond_pass = 1'b0;
        unique case (Cond)
            4'b0000: cond_pass = flag_z;                          // EQ
            4'b0001: cond_pass = ~flag_z;                         // NE
            4'b0010: cond_pass = flag_c;                          // CS/HS
            4'b0011: cond_pass = ~flag_c;                         // CC/LO
            4'b0100: cond_pass = flag_n;                          // MI
            4'b0101: cond_pass = ~flag_n;                         // PL
            4'b0110: cond_pass = flag_v;                          // VS
            4'b0111: cond_pass = ~flag_v;                         // VC
            4'b1000: cond_pass = flag_c & ~flag_z;                // HI
            4'b1001: cond_pass = ~flag_c | flag_z;                // LS
            4'b1010: cond_pass = ~(flag_n ^ flag_v);              // GE
            4'b1011: cond_pass = flag_n ^ flag_v;                 // LT
            4'b1100: cond_pass = ~flag_z & ~(flag_n ^ flag_v);    // GT
            4'b1101: cond_pass = flag_z | (flag_n ^ flag_v);      // LE
            4'b1110: cond_pass = 1'b1;                            // AL
            4'b1111: cond_pass = 1'b0;                            // NV
            default: cond_pass = 1'b0;
        endcase
    end

    // A flushed instruction behaves exactly like a failed condition for
    // every side effect, but it is not a real skip so it is not counted.
    logic cond_ex;
    assign cond_ex = cond_pass & ~Flush;

    // ------------------------------------------------------------------
    // Gated write-enables before the optional output register
    // ------------------------------------------------------------------
    logic pcsrc_c;
    logic regwrite_c;
    logic memwrite_c;

    assign pcsrc_c    = PCS & cond_ex;
    assign regwrite_c = RegW & ~NoWrite & cond_ex;
    assign memwrite_c = MemW & cond_ex;

    // ------------------------------------------------------------------
    // Flag update. The two halves are enabled independently so that
    // e.g. a logical op with S set can update N,Z while preserving C,V.
    // ------------------------------------------------------------------
    logic flag_upd;
    assign flag_upd = cond_ex & ~Stall;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            flags_q <= 4'b0000;
        end else if (flag_upd) begin
            if (FlagW[1]) begin
                flags_q[3:2] <= ALUFlags[3:2];
            end
            if (FlagW[0]) begin
                flags_q[1:0] <= ALUFlags[1:0];
            end
        end
    end

    // ------------------------------------------------------------------
    // Skip counter: counts genuine condition failures only (Flush and
    // Stall excluded). Saturates so a long debug run never wraps to a
    // misleadingly small number.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] skip_q;
    logic             skip_inc;
    logic             skip_sat;

    assign skip_inc = ~Stall & ~Flush & ~cond_pass;
    assign skip_sat = &skip_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            skip_q <= '0;
        end else if (skip_inc && !skip_sat) begin
            skip_q <= skip_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // ------------------------------------------------------------------
    // Optional output register for the gated enables. When present the
    // enables follow their instruction by one cycle and hold across a
    // stall, so the consumer sees a stable enable for the whole hold.
    // ------------------------------------------------------------------
    generate
        if (REG_OUT) begin : g_reg_out
            logic pcsrc_q;
            logic regwrite_q;
            logic memwrite_q;

            always_ff @(posedge CLK or posedge RESET) begin
                if (RESET) begin
                    pcsrc_q    <= 1'b0;
                    regwrite_q <= 1'b0;
                    memwrite_q <= 1'b0;
                end else if (!Stall) begin
                    pcsrc_q    <= pcsrc_c;
                    regwrite_q <= regwrite_c;
                    memwrite_q <= memwrite_c;
                end
            end

            assign PCSrc    = pcsrc_q;
            assign RegWrite = regwrite_q;
            assign MemWrite = memwrite_q;
        end else begin : g_comb_out
            assign PCSrc    = pcsrc_c;
            assign RegWrite = regwrite_c;
            assign MemWrite = memwrite_c;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Remaining outputs
    // ------------------------------------------------------------------
    assign CondEx    = cond_ex;
    assign Flags     = flags_q;
    assign Carry     = flags_q[1];
    assign SkipCount = skip_q;

endmodule

// File: tb/tb_cond_flag_unit.sv
// Purpose : self-checking bench for cond_flag_unit (combinational and registered-output builds).
// Latency : one step per clock; inputs driven 1 ns after the edge, outputs sampled 4 ns after.
// Backpres: Stall/Flush exercised by directed rows and random stimulus.
module tb_cond_flag_unit;

    logic       clk;
    logic       rst;
    logic [3:0] cond;
    logic [3:0] alu_flags;
    logic [1:0] flag_w;
    logic       pcs, regw, memw, no_write, stall, flush;

    // instance a: CNT_W=16, combinational enables
    logic        pcsrc_a, regwrite_a, memwrite_a, condex_a, carry_a;
    logic [3:0]  flags_a;
    logic [15:0] skip_a;
    // instance b: CNT_W=4, registered enables
    logic        pcsrc_b, regwrite_b, memwrite_b, condex_b, carry_b;
    logic [3:0]  flags_b;
    logic [3:0]  skip_b;

    cond_flag_unit #(.CNT_W(16), .REG_OUT(1'b0)) dut_a (
        .CLK(clk), .RESET(rst), .Cond(cond), .ALUFlags(alu_flags), .FlagW(flag_w),
        .PCS(pcs), .RegW(regw), .MemW(memw), .NoWrite(no_write), .Stall(stall), .Flush(flush),
        .PCSrc(pcsrc_a), .RegWrite(regwrite_a), .MemWrite(memwrite_a), .CondEx(condex_a),
        .Flags(flags_a), .Carry(carry_a), .SkipCount(skip_a)
    );

    cond_flag_unit #(.CNT_W(4), .REG_OUT(1'b1)) dut_b (
        .CLK(clk), .RESET(rst), .Cond(cond), .ALUFlags(alu_flags), .FlagW(flag_w),
        .PCS(pcs), .RegW(regw), .MemW(memw), .NoWrite(no_write), .Stall(stall), .Flush(flush),
        .PCSrc(pcsrc_b), .RegWrite(regwrite_b), .MemWrite(memwrite_b), .CondEx(condex_b),
        .Flags(flags_b), .Carry(carry_b), .SkipCount(skip_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [3:0] m_flags;
    int         m_skip_a;
    int         m_skip_b;
    logic [2:0] m_reg;      // {PCSrc, RegWrite, MemWrite} of the registered build

    // Conditions come in complementary pairs: the odd code is the negation
    // of the even one below it (AL/NV included).
    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, base;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    function automatic void model_reset();
        m_flags  = 4'b0000;
        m_skip_a = 0;
        m_skip_b = 0;
        m_reg    = 3'b000;
    endfunction

    function automatic void model_edge();
        logic pass, cex;
        pass = cond_ok(cond, m_flags);
        cex  = pass && !flush;
        if (!stall) begin
            m_reg = {pcs && cex, regw && !no_write && cex, memw && cex};
            if (cex) begin
                if (flag_w[1]) m_flags[3:2] = alu_flags[3:2];
                if (flag_w[0]) m_flags[1:0] = alu_flags[1:0];
            end
            if (!flush && !pass) begin
                if (m_skip_a < 65535) m_skip_a++;
                if (m_skip_b < 15)    m_skip_b++;
            end
        end
    endfunction

    // ------------------------------------------------------------------
    // Vector record
    // ------------------------------------------------------------------
    typedef struct {
        logic [3:0] cond;
        logic [3:0] alu;
        logic [1:0] fw;
        logic [5:0] ctl;        // {pcs, regw, memw, nowrite, stall, flush}
        logic       exp_condex;
        logic [3:0] exp_flags;
        logic       exp_regwrite;
        int         exp_skip;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] c, input logic [3:0] a, input logic [1:0] fw,
                                input logic [5:0] ctl, input logic ec, input logic [3:0] ef,
                                input logic er, input int es);
        vec_t r;
        r.cond = c; r.alu = a; r.fw = fw; r.ctl = ctl;
        r.exp_condex = ec; r.exp_flags = ef; r.exp_regwrite = er; r.exp_skip = es;
        return r;
    endfunction

    task automatic drive(input vec_t v);
        cond      = v.cond;
        alu_flags = v.alu;
        flag_w    = v.fw;
        {pcs, regw, memw, no_write, stall, flush} = v.ctl;
    endtask

    // One clock: drive, sample mid-cycle against model (and table if asked), clock, update model.
    task automatic step(input vec_t v, input bit use_exp);
        logic pass, cex;
        drive(v);
        #3;
        pass = cond_ok(cond, m_flags);
        cex  = pass && !flush;
        chk("condex_a",   condex_a,   cex);
        chk("pcsrc_a",    pcsrc_a,    pcs && cex);
        chk("regwrite_a", regwrite_a, regw && !no_write && cex);
        chk("memwrite_a", memwrite_a, memw && cex);
        chk("flags_a",    flags_a,    m_flags);
        chk("carry_a",    carry_a,    m_flags[1]);
        chk("skip_a",     skip_a,     m_skip_a);
        chk("condex_b",   condex_b,   cex);
        chk("flags_b",    flags_b,    m_flags);
        chk("carry_b",    carry_b,    m_flags[1]);
        chk("skip_b",     skip_b,     m_skip_b);
        chk("regout_b",   {pcsrc_b, regwrite_b, memwrite_b}, m_reg);
        if (use_exp) begin
            chk("tbl_condex",   condex_a,   v.exp_condex);
            chk("tbl_flags",    flags_a,    v.exp_flags);
            chk("tbl_regwrite", regwrite_a, v.exp_regwrite);
            chk("tbl_skip",     skip_a,     v.exp_skip);
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    vec_t tbl[13];
    vec_t idle;
    vec_t rv;

    initial begin
        idle = mk(4'hE, 4'h0, 2'b00, 6'b000000, 1'b1, 4'h0, 1'b0, 0);
        // cond, alu, fw, {pcs,regw,memw,nowr,stall,flush}, exp CondEx, exp Flags, exp RegWrite, exp Skip
        tbl[0]  = mk(4'hE, 4'h6, 2'b11, 6'b010000, 1'b1, 4'h0, 1'b1, 0); // AL, write 0110
        tbl[1]  = mk(4'h0, 4'h0, 2'b00, 6'b000000, 1'b1, 4'h6, 1'b0, 0); // EQ, Z=1
        tbl[2]  = mk(4'h8, 4'h0, 2'b00, 6'b000000, 1'b0, 4'h6, 1'b0, 0); // HI fails: C=1,Z=1
        tbl[3]  = mk(4'hE, 4'h8, 2'b11, 6'b000000, 1'b1, 4'h6, 1'b0, 1); // flags -> 1000
        tbl[4]  = mk(4'hE, 4'h3, 2'b01, 6'b000000, 1'b1, 4'h8, 1'b0, 1); // only C,V -> 1011
        tbl[5]  = mk(4'hA, 4'h0, 2'b00, 6'b000000, 1'b1, 4'hB, 1'b0, 1); // GE, N=V=1
        tbl[6]  = mk(4'hE, 4'h4, 2'b10, 6'b000000, 1'b1, 4'hB, 1'b0, 1); // only N,Z -> 0111
        tbl[7]  = mk(4'h1, 4'hF, 2'b11, 6'b111000, 1'b0, 4'h7, 1'b0, 1); // NE fails, all gated off
        tbl[8]  = mk(4'h1, 4'hF, 2'b11, 6'b111010, 1'b0, 4'h7, 1'b0, 2); // same, stalled: no count
        tbl[9]  = mk(4'hE, 4'h0, 2'b11, 6'b000001, 1'b0, 4'h7, 1'b0, 2); // flushed AL
        tbl[10] = mk(4'hF, 4'hF, 2'b11, 6'b000000, 1'b0, 4'h7, 1'b0, 2); // NV never writes
        tbl[11] = mk(4'hD, 4'h0, 2'b00, 6'b010100, 1'b1, 4'h7, 1'b0, 3); // LE passes, NoWrite
        tbl[12] = mk(4'hE, 4'h0, 2'b11, 6'b000011, 1'b0, 4'h7, 1'b0, 3); // stall+flush

        // power-on reset
        drive(idle);
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #4 rst = 1'b0;
        #1;
        chk("rst_flags_a", flags_a, 4'h0);
        chk("rst_skip_a",  skip_a,  16'h0);
        chk("rst_carry_a", carry_a, 1'b0);
        chk("rst_regout_b", {pcsrc_b, regwrite_b, memwrite_b}, 3'b000);
        @(posedge clk);
        model_edge();
        #1;

        // directed table
        for (int i = 0; i < 13; i++) step(tbl[i], 1'b1);

        // saturation of the 4-bit counter
        for (int i = 0; i < 20; i++) step(mk(4'hF, 4'h0, 2'b00, 6'b000000, 0, 0, 0, 0), 1'b0);
        chk("sat_skip_b", skip_b, 4'hF);
        chk("nosat_skip_a", skip_a, 16'd23);

        // registered enables: NoWrite then write then stall-hold
        step(mk(4'hE, 4'h0, 2'b00, 6'b010100, 0, 0, 0, 0), 1'b0);
        chk("regout_nowrite", regwrite_b, 1'b0);
        step(mk(4'hE, 4'h0, 2'b00, 6'b010000, 0, 0, 0, 0), 1'b0);
        chk("regout_write", regwrite_b, 1'b1);
        step(mk(4'hE, 4'h0, 2'b00, 6'b000010, 0, 0, 0, 0), 1'b0);
        chk("regout_stall_hold", regwrite_b, 1'b1);

        // async reset mid-cycle with all flags set
        step(mk(4'hE, 4'hF, 2'b11, 6'b010000, 0, 0, 0, 0), 1'b0);
        #1;
        chk("pre_rst_flags", flags_a, 4'hF);
        rst = 1'b1;
        #1;
        chk("async_rst_flags_a", flags_a, 4'h0);
        chk("async_rst_carry_a", carry_a, 1'b0);
        chk("async_rst_skip_a",  skip_a,  16'h0);
        chk("async_rst_skip_b",  skip_b,  4'h0);
        chk("async_rst_regout_b", {pcsrc_b, regwrite_b, memwrite_b}, 3'b000);
        model_reset();
        #1 rst = 1'b0;
        drive(idle);
        @(posedge clk);
        model_edge();
        #1;

        // random stimulus against the model
        for (int i = 0; i < 400; i++) begin
            rv.cond = 4'($urandom_range(15));
            rv.alu  = 4'($urandom_range(15));
            rv.fw   = 2'($urandom_range(3));
            rv.ctl[5:2] = 4'($urandom_range(15));
            rv.ctl[1]   = ($urandom_range(7) == 0);
            rv.ctl[0]   = ($urandom_range(7) == 0);
            rv.exp_condex = 1'b0; rv.exp_flags = 4'h0; rv.exp_regwrite = 1'b0; rv.exp_skip = 0;
            step(rv, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
